// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared encodings for the multi-cycle MIPS-subset control unit.
// State codes, opcode/funct constants, ALU op codes and datapath mux encodings.
package mctrl_pkg;

   // Controller states; the numeric codes are visible on the debug state port
   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMaddr  = 4'd2,
      StMread  = 4'd3,
      StWbmem  = 4'd4,
      StMwrite = 4'd5,
      StExr    = 4'd6,
      StWbr    = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StExi    = 4'd10,
      StWbi    = 4'd11
   } state_e;

   // ALU operation class chosen by the state, refined by alu_dec
   typedef enum logic [1:0] {
      AluOpAdd   = 2'd0,
      AluOpSub   = 2'd1,
      AluOpFunct = 2'd2,
      AluOpImm   = 2'd3
   } alu_op_e;

   // Opcodes, IR[31:26]
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type funct codes, IR[5:0]
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // ALU control codes
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALU B-operand select
   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   // PC source select
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // True when an R-type funct field names a supported operation
   function automatic logic funct_ok(input logic [5:0] funct);
      logic r_ok;
      case (funct)
         FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLT: r_ok = 1'b1;
         default:                                       r_ok = 1'b0;
      endcase
      return r_ok;
   endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec: combinational ALU control decoder. Maps the state-selected op class
// plus funct/opcode onto the 3-bit ALU control code.
module alu_dec
   import mctrl_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [5:0] i_funct,
   input  logic [5:0] i_opcode,
   output logic [2:0] o_alu_ctrl
);

   // Decode ALU control; anything unrecognised falls back to add
   always_comb begin
      o_alu_ctrl = ALU_ADD;
      case (i_alu_op)
         AluOpAdd: o_alu_ctrl = ALU_ADD;
         AluOpSub: o_alu_ctrl = ALU_SUB;
         AluOpFunct: begin
            case (i_funct)
               FN_ADD:  o_alu_ctrl = ALU_ADD;
               FN_SUB:  o_alu_ctrl = ALU_SUB;
               FN_AND:  o_alu_ctrl = ALU_AND;
               FN_OR:   o_alu_ctrl = ALU_OR;
               FN_XOR:  o_alu_ctrl = ALU_XOR;
               FN_SLT:  o_alu_ctrl = ALU_SLT;
               default: o_alu_ctrl = ALU_ADD;
            endcase
         end
         AluOpImm: begin
            case (i_opcode)
               OP_ANDI: o_alu_ctrl = ALU_AND;
               OP_ORI:  o_alu_ctrl = ALU_OR;
               OP_SLTI: o_alu_ctrl = ALU_SLT;
               default: o_alu_ctrl = ALU_ADD;
            endcase
         end
         default: o_alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multi_ctrl.sv
// multi_ctrl: Moore control FSM for the multi-cycle MIPS-subset CPU.
// Define MULTI_CTRL_WAIT_EN to honour i_mem_ready; otherwise memory states take
// exactly one cycle and i_mem_ready is ignored.
module multi_ctrl
   import mctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   output logic [2:0] o_alu_ctrl,
   output logic       o_alu_src_a,
   output logic [1:0] o_alu_src_b,
   output logic       o_ext_zero,
   output logic [1:0] o_pc_source,
   output logic       o_pc_en,
   output logic       o_ior,
   output logic       o_mem_read,
   output logic       o_mem_write,
   output logic       o_ir_write,
   output logic       o_reg_dst,
   output logic       o_mem_to_reg,
   output logic       o_reg_write,
   output logic       o_illegal,
   output logic [3:0] o_state
);

   state_e  r_state;
   state_e  w_state_next;
   alu_op_e w_alu_op;
   logic    w_ready;

`ifdef MULTI_CTRL_WAIT_EN
   assign w_ready = i_mem_ready;
`else
   // Port kept for a uniform interface; its value has no effect
   assign w_ready = i_mem_ready | 1'b1;
`endif

   assign o_state = r_state;

   // State register; reset lands in FETCH immediately
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StFetch;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and per-state datapath controls
   always_comb begin
      w_state_next = StFetch;
      w_alu_op     = AluOpAdd;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = SRCB_REGB;
      o_ext_zero   = 1'b0;
      o_pc_source  = PCSRC_ALU;
      o_pc_en      = 1'b0;
      o_ior        = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_ir_write   = 1'b0;
      o_reg_dst    = 1'b0;
      o_mem_to_reg = 1'b0;
      o_reg_write  = 1'b0;
      o_illegal    = 1'b0;
      case (r_state)
         StFetch: begin
            // Read instruction at PC and compute PC+4 in the same cycle
            o_mem_read   = 1'b1;
            o_alu_src_b  = SRCB_FOUR;
            o_pc_source  = PCSRC_ALU;
            o_ir_write   = w_ready;
            o_pc_en      = w_ready;
            w_state_next = w_ready ? StDecode : StFetch;
         end
         StDecode: begin
            // Speculative branch target into ALUOut
            o_alu_src_b = SRCB_IMMSH;
            case (i_opcode)
               OP_LW, OP_SW:    w_state_next = StMaddr;
               OP_BEQ, OP_BNE:  w_state_next = StBranch;
               OP_J:            w_state_next = StJump;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: w_state_next = StExi;
               OP_RTYPE: begin
                  if (funct_ok(i_funct)) begin
                     w_state_next = StExr;
                  end else begin
                     o_illegal    = 1'b1;
                     w_state_next = StFetch;
                  end
               end
               default: begin
                  o_illegal    = 1'b1;
                  w_state_next = StFetch;
               end
            endcase
         end
         StMaddr: begin
            o_alu_src_a  = 1'b1;
            o_alu_src_b  = SRCB_IMM;
            w_state_next = (i_opcode == OP_SW) ? StMwrite : StMread;
         end
         StMread: begin
            o_ior        = 1'b1;
            o_mem_read   = 1'b1;
            w_state_next = w_ready ? StWbmem : StMread;
         end
         StWbmem: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 1'b1;
            o_reg_dst    = 1'b0;
            w_state_next = StFetch;
         end
         StMwrite: begin
            o_ior        = 1'b1;
            o_mem_write  = 1'b1;
            w_state_next = w_ready ? StFetch : StMwrite;
         end
         StExr: begin
            o_alu_src_a  = 1'b1;
            o_alu_src_b  = SRCB_REGB;
            w_alu_op     = AluOpFunct;
            w_state_next = StWbr;
         end
         StWbr: begin
            o_reg_write  = 1'b1;
            o_reg_dst    = 1'b1;
            w_state_next = StFetch;
         end
         StBranch: begin
            // Compare regs; taken branch loads the target saved in DECODE
            o_alu_src_a  = 1'b1;
            o_alu_src_b  = SRCB_REGB;
            w_alu_op     = AluOpSub;
            o_pc_source  = PCSRC_ALUOUT;
            o_pc_en      = (i_opcode == OP_BEQ) ? i_zero : ~i_zero;
            w_state_next = StFetch;
         end
         StJump: begin
            o_pc_source  = PCSRC_JUMP;
            o_pc_en      = 1'b1;
            w_state_next = StFetch;
         end
         StExi: begin
            o_alu_src_a  = 1'b1;
            o_alu_src_b  = SRCB_IMM;
            w_alu_op     = AluOpImm;
            o_ext_zero   = (i_opcode == OP_ANDI) || (i_opcode == OP_ORI);
            w_state_next = StWbi;
         end
         StWbi: begin
            o_reg_write  = 1'b1;
            o_reg_dst    = 1'b0;
            w_state_next = StFetch;
         end
         default: w_state_next = StFetch;
      endcase
   end

   alu_dec u_alu_dec (
      .i_alu_op   (w_alu_op),
      .i_funct    (i_funct),
      .i_opcode   (i_opcode),
      .o_alu_ctrl (o_alu_ctrl)
   );

endmodule

// File: tb/tb_multi_ctrl.sv
// tb_multi_ctrl: directed and randomized checks of multi_ctrl against an
// instruction-level model (per-instruction state lists plus a per-state output table).
module tb_multi_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h20;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;

   logic [2:0] alu_ctrl;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       ext_zero;
   logic [1:0] pc_source;
   logic       pc_en, ior, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, illegal;
   logic [3:0] state;

   multi_ctrl dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_opcode     (opcode),
      .i_funct      (funct),
      .i_zero       (zero),
      .i_mem_ready  (mem_ready),
      .o_alu_ctrl   (alu_ctrl),
      .o_alu_src_a  (alu_src_a),
      .o_alu_src_b  (alu_src_b),
      .o_ext_zero   (ext_zero),
      .o_pc_source  (pc_source),
      .o_pc_en      (pc_en),
      .o_ior        (ior),
      .o_mem_read   (mem_read),
      .o_mem_write  (mem_write),
      .o_ir_write   (ir_write),
      .o_reg_dst    (reg_dst),
      .o_mem_to_reg (mem_to_reg),
      .o_reg_write  (reg_write),
      .o_illegal    (illegal),
      .o_state      (state)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: current state plus the states still to visit for this instruction
   int m_cur = 0;
   int m_q[$];

   // Stimulus control
   logic       rand_mode = 1'b0;
   logic       rst_hold = 1'b0;
   logic       mid_rst_req = 1'b0;
   logic [5:0] d_op = 6'h00;
   logic [5:0] d_fn = 6'h20;
   logic       d_zero = 1'b0;
   int         d_stall_left = 0;
   int         d_rdy_mode = 0;

   // Per-instruction observation logs
   logic [63:0] seq_log;
   logic [15:0] rw_log;
   logic [2:0]  cap_alu[16];
   logic        cap_extz[16];
   logic [1:0]  cap_srcb[16];
   logic        cap_pcen[16];
   logic [1:0]  cap_pcs[16];
   logic        cap_ior[16];
   logic        cap_rd[16];
   logic        wr_any;
   int          ill_cnt;
   int          ncyc;
   logic [3:0]  pre_state;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic supported(input logic [5:0] op, input logic [5:0] fn);
      logic ok;
      case (op)
         6'h00: ok = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) ||
                     (fn == 6'h25) || (fn == 6'h26) || (fn == 6'h2A);
         6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [2:0] fn_alu(input logic [5:0] fn);
      logic [2:0] r;
      case (fn)
         6'h22:   r = 3'b110;
         6'h24:   r = 3'b000;
         6'h25:   r = 3'b001;
         6'h26:   r = 3'b011;
         6'h2A:   r = 3'b111;
         default: r = 3'b010;
      endcase
      return r;
   endfunction

   // Expected outputs for one cycle, from the per-state table of the controller
   function automatic logic [21:0] model_out(input int st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic z,
                                             input logic rdy);
      logic [2:0] alu = 3'b010;
      logic a = 0, ez = 0, pcen = 0, io = 0, mr = 0, mw = 0, irw = 0;
      logic rd = 0, m2r = 0, rw = 0, ill = 0;
      logic [1:0] b = 2'b00, pcs = 2'b00;
      logic [3:0] s4;
      s4 = st[3:0];
      case (st)
         0:  begin mr = 1; b = 2'b01; irw = rdy; pcen = rdy; end
         1:  begin b = 2'b11; ill = !supported(op, fn); end
         2:  begin a = 1; b = 2'b10; end
         3:  begin io = 1; mr = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin io = 1; mw = 1; end
         6:  begin a = 1; alu = fn_alu(fn); end
         7:  begin rw = 1; rd = 1; end
         8:  begin alu = 3'b110; a = 1; pcs = 2'b01; pcen = (op == 6'h04) ? z : !z; end
         9:  begin pcs = 2'b10; pcen = 1; end
         10: begin
            a = 1; b = 2'b10;
            if (op == 6'h0C) begin alu = 3'b000; ez = 1; end
            else if (op == 6'h0D) begin alu = 3'b001; ez = 1; end
            else if (op == 6'h0A) alu = 3'b111;
         end
         11: rw = 1;
         default: ;
      endcase
      return {alu, a, b, ez, pcs, pcen, io, mr, mw, irw, rd, m2r, rw, ill, s4};
   endfunction

   // States an instruction visits after FETCH
   task automatic load_seq(input logic [5:0] op, input logic [5:0] fn);
      m_q.delete();
      m_q.push_back(1);
      if (supported(op, fn)) begin
         case (op)
            6'h23:        begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
            6'h2B:        begin m_q.push_back(2); m_q.push_back(5); end
            6'h00:        begin m_q.push_back(6); m_q.push_back(7); end
            6'h04, 6'h05: m_q.push_back(8);
            6'h02:        m_q.push_back(9);
            default:      begin m_q.push_back(10); m_q.push_back(11); end
         endcase
      end
   endtask

   task automatic model_step(input logic rdy);
      if (!rst_n) begin
         m_cur = 0;
         m_q.delete();
      end else if ((m_cur == 0 || m_cur == 3 || m_cur == 5) && !rdy) begin
         m_cur = m_cur;
      end else if (m_cur == 0) begin
         load_seq(opcode, funct);
         m_cur = m_q.pop_front();
      end else if (m_q.size() == 0) begin
         m_cur = 0;
      end else begin
         m_cur = m_q.pop_front();
      end
   endtask

   task automatic pick_random_instr();
      logic [5:0] ops[11];
      logic [5:0] fns[7];
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h00};
      opcode = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) opcode = 6'($urandom_range(0, 63));
      funct = fns[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) funct = 6'($urandom_range(0, 63));
   endtask

   task automatic clear_logs();
      seq_log = '0;
      rw_log  = '0;
      wr_any  = 1'b0;
      ill_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         cap_alu[i] = 3'b000; cap_extz[i] = 1'b0; cap_srcb[i] = 2'b00;
         cap_pcen[i] = 1'b0; cap_pcs[i] = 2'b00; cap_ior[i] = 1'b0; cap_rd[i] = 1'b0;
      end
   endtask

   // One clock: drive at negedge+1, compare at negedge+2, advance the model
   task automatic cycle();
      logic [21:0] exp_v, act_v;
      logic        rdy_eff;
      @(negedge clk);
      #1;
      if (!rst_hold) rst_n = 1'b1;
      if (rand_mode) begin
         zero      = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 3) != 0);
         if (m_cur == 0) pick_random_instr();
         if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      end else begin
         opcode = d_op;
         funct  = d_fn;
         zero   = d_zero;
         if (d_rdy_mode == 1) begin
            mem_ready = 1'b0;
         end else if ((m_cur == 3 || m_cur == 5) && d_stall_left > 0) begin
            mem_ready = 1'b0;
            d_stall_left--;
         end else begin
            mem_ready = 1'b1;
         end
      end
      if (!rst_n) begin
         m_cur = 0;
         m_q.delete();
      end
      #1;
`ifdef MULTI_CTRL_WAIT_EN
      rdy_eff = mem_ready;
`else
      rdy_eff = 1'b1;
`endif
      exp_v = model_out(m_cur, opcode, funct, zero, rdy_eff);
      act_v = {alu_ctrl, alu_src_a, alu_src_b, ext_zero, pc_source, pc_en, ior, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal, state};
      chk("outputs", {10'd0, act_v}, {10'd0, exp_v});
      seq_log = {seq_log[59:0], state};
      rw_log  = {rw_log[14:0], reg_write};
      cap_alu[state]  = alu_ctrl;
      cap_extz[state] = ext_zero;
      cap_srcb[state] = alu_src_b;
      cap_pcen[state] = pc_en;
      cap_pcs[state]  = pc_source;
      cap_ior[state]  = ior;
      cap_rd[state]   = reg_dst;
      wr_any  = wr_any | reg_write | mem_write;
      ill_cnt = ill_cnt + int'(illegal);
      model_step(rdy_eff);
      if (mid_rst_req) begin
         mid_rst_req = 1'b0;
         pre_state   = state;
         rst_n       = 1'b0;
         #1;
         chk("mid_rst_state", {28'd0, state}, 32'd0);
         chk("mid_rst_reg_write", {31'd0, reg_write}, 32'd0);
         chk("mid_rst_mem_read", {31'd0, mem_read}, 32'd1);
         chk("mid_rst_pc_en", {31'd0, pc_en}, {31'd0, rdy_eff});
         m_cur = 0;
         m_q.delete();
      end
      @(posedge clk);
   endtask

   task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int stalls, input int mode);
      logic left;
      d_op = op; d_fn = fn; d_zero = z; d_stall_left = stalls; d_rdy_mode = mode;
      clear_logs();
      ncyc = 0;
      left = 1'b0;
      while (1) begin
         cycle();
         ncyc++;
         if (m_cur != 0) left = 1'b1;
         else if (left) break;
         if (ncyc > 40) begin
            chk("instr_timeout", 32'd1, 32'd0);
            break;
         end
      end
      d_rdy_mode = 0;
   endtask

   initial begin
      clear_logs();
      // Reset held: outputs must show FETCH values
      rst_hold = 1'b1;
      repeat (3) cycle();
      rst_hold = 1'b0;

      // add: 0,1,6,7 then FETCH
      do_instr(6'h00, 6'h20, 1'b0, 0, 0);
      chk("add_seq", seq_log[31:0], 32'h0000_0167);
      chk("add_cycles", ncyc, 32'd4);
      chk("add_alu", {29'd0, cap_alu[6]}, 32'd2);
      chk("add_rw_last_only", {28'd0, rw_log[3:0]}, 32'h1);
      chk("add_reg_dst", {31'd0, cap_rd[7]}, 32'd1);

      // Reset asserted while in WBR
      begin
         int guard = 0;
         d_op = 6'h00; d_fn = 6'h22; d_zero = 1'b0; d_stall_left = 0;
         while (m_cur != 7 && guard < 10) begin
            cycle();
            guard++;
         end
         mid_rst_req = 1'b1;
         cycle();
         chk("rst_pre_state", {28'd0, pre_state}, 32'd7);
      end

      // lw with two stall cycles in MREAD
      do_instr(6'h23, 6'h00, 1'b0, 2, 0);
`ifdef MULTI_CTRL_WAIT_EN
      chk("lw_seq", seq_log[31:0], 32'h0123_3340 >> 4);
      chk("lw_cycles", ncyc, 32'd7);
`else
      chk("lw_seq", seq_log[31:0], 32'h0001_2340 >> 4);
      chk("lw_cycles", ncyc, 32'd5);
`endif
      chk("lw_ior", {31'd0, cap_ior[3]}, 32'd1);

      // beq taken, bne not taken, both with zero=1
      do_instr(6'h04, 6'h00, 1'b1, 0, 0);
      chk("beq_pc_en", {31'd0, cap_pcen[8]}, 32'd1);
      chk("beq_pc_source", {30'd0, cap_pcs[8]}, 32'd1);
      chk("beq_cycles", ncyc, 32'd3);
      do_instr(6'h05, 6'h00, 1'b1, 0, 0);
      chk("bne_pc_en", {31'd0, cap_pcen[8]}, 32'd0);
      chk("bne_seq", seq_log[31:0], 32'h0000_0018);

      // j
      do_instr(6'h02, 6'h00, 1'b0, 0, 0);
      chk("j_seq", seq_log[31:0], 32'h0000_0019);

      // ori / slti
      do_instr(6'h0D, 6'h00, 1'b0, 0, 0);
      chk("ori_alu", {29'd0, cap_alu[10]}, 32'd1);
      chk("ori_ext_zero", {31'd0, cap_extz[10]}, 32'd1);
      chk("ori_src_b", {30'd0, cap_srcb[10]}, 32'd2);
      chk("ori_seq", seq_log[31:0], 32'h0000_01AB);
      do_instr(6'h0A, 6'h00, 1'b0, 0, 0);
      chk("slti_alu", {29'd0, cap_alu[10]}, 32'd7);
      chk("slti_ext_zero", {31'd0, cap_extz[10]}, 32'd0);

      // Illegal opcode
      do_instr(6'h3F, 6'h00, 1'b0, 0, 0);
      chk("ill_count", ill_cnt, 32'd1);
      chk("ill_seq", seq_log[31:0], 32'h0000_0001);
      chk("ill_no_write", {31'd0, wr_any}, 32'd0);

`ifdef MULTI_CTRL_WAIT_EN
      // sw with one stall in MWRITE
      do_instr(6'h2B, 6'h00, 1'b0, 1, 0);
      chk("sw_seq", seq_log[31:0], 32'h0001_2555 >> 4);
      chk("sw_cycles", ncyc, 32'd5);
`else
      // sw with mem_ready held low throughout
      do_instr(6'h2B, 6'h00, 1'b0, 0, 1);
      chk("sw_seq", seq_log[31:0], 32'h0000_0125);
      chk("sw_cycles", ncyc, 32'd4);
`endif

      // Randomized run against the model
      rand_mode = 1'b1;
      repeat (3000) cycle();
      rand_mode = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multi_ctrl.md
# multi_ctrl

Multi-cycle control unit for the 32-bit MIPS-subset CPU. A Moore state machine sequences instruction fetch, decode, execute, memory and write-back. Each cycle it produces the datapath mux selects, the register-file, IR and memory strobes, and the 3-bit operation code for the shared 32-bit ALU. It sits between the instruction register and the datapath, and the ALU is reused for PC+4, branch target, address and result computation.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same-cycle combinational
- mem_ready  in  1  memory access completes this cycle
- alu_ctrl  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 const 4, 10 extended imm, 11 imm<<2
- ext_zero  out  1  1 = zero-extend imm (andi/ori), 0 = sign-extend
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- pc_en  out  1  PC load enable
- ior  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read, mem_write  out  1  memory strobes
- ir_write  out  1  IR load enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- reg_write  out  1  register-file write
- illegal  out  1  one-cycle pulse in DECODE when the opcode or funct is unsupported
- state  out  4  current state, for debug

## Operation
- Supported instructions:
  - R-type add/sub/and/or/xor/slt, funct 20/22/24/25/26/2A hex
  - lw 23, sw 2B, beq 04, bne 05, j 02, addi 08, andi 0C, ori 0D, slti 0A
- States and codes:
  - FETCH 0: ior=0, mem_read, ALU PC+4 (add, a=0, b=01), pc_source=00. ir_write and pc_en assert only when mem_ready. Go to DECODE on mem_ready, otherwise stay.
  - DECODE 1: ALU PC+(imm<<2) (add, a=0, b=11). Next state by opcode: lw/sw→MADDR, R→EXR, beq/bne→BRANCH, j→JUMP, I-ALU→EXI, else FETCH with illegal=1.
  - MADDR 2: add, a=1, b=10. Go to MREAD (lw) or MWRITE (sw).
  - MREAD 3: ior=1, mem_read. Go to WBMEM on mem_ready.
  - WBMEM 4: reg_write, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MWRITE 5: ior=1, mem_write. Go to FETCH on mem_ready.
  - EXR 6: a=1, b=00, alu_ctrl decoded from funct. Go to WBR.
  - WBR 7: reg_write, reg_dst=1. Go to FETCH.
  - BRANCH 8: sub, a=1, b=00, pc_source=01. pc_en = zero for beq, !zero for bne. Go to FETCH.
  - JUMP 9: pc_source=10, pc_en=1. Go to FETCH.
  - EXI 10: a=1, b=10. Ops: addi→add, andi→and with ext_zero, ori→or with ext_zero, slti→slt. Go to WBI.
  - WBI 11: reg_write, reg_dst=0. Go to FETCH.
- Undefined state codes go to FETCH.
- Any output not listed for a state is 0, and alu_ctrl defaults to 010.

## Timing
- State is registered and outputs are decoded from it, except pc_en in BRANCH and ir_write/pc_en in FETCH, which are combinational on zero and mem_ready.
- Cycles with zero wait: lw 5, sw 4, R 4, I-ALU 4, beq/bne 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MREAD or MWRITE adds one cycle. Strobes hold steady throughout a stall.
- Reset: state=FETCH immediately and asynchronously. While reset is held, outputs show FETCH values: mem_read=1, alu_ctrl=010, alu_src_b=01, all others 0, and ir_write/pc_en follow mem_ready.
- Reset asserted mid-instruction abandons it, and there is no write after reset.
- illegal never coincides with reg_write or mem_write.

## Configuration
- MULTI_CTRL_WAIT_EN defined: mem_ready is honoured as described above.
- MULTI_CTRL_WAIT_EN undefined: mem_ready is ignored and treated as 1, so every memory state lasts exactly one cycle. The port remains present.

## Structure
- Package mctrl_pkg holds:
  - the state codes
  - opcode and funct constants
  - ALU op codes (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_XOR=011, ALU_SLT=111)
  - alu_src_b and pc_source encodings
- Sub-module alu_dec: purely combinational. Takes the state-derived alu_op class (add/sub/funct/imm) plus funct and opcode, and produces alu_ctrl.

## Test plan
- Reset asserted in WBR (state=7) → state=0 at once, reg_write=0, mem_read=1, pc_en=mem_ready.
- add (funct 20), mem_ready=1 → states 0,1,6,7,0; alu_ctrl=010 in EXR; reg_write=1 with reg_dst=1 only in cycle 4.
- lw with mem_ready low for 2 cycles in MREAD → states 0,1,2,3,3,3,4,0; mem_read and ior=1 held during the stall; lw takes 7 cycles.
- beq with zero=1 → pc_en=1, pc_source=01 in BRANCH. bne with zero=1 → pc_en=0. Both return to FETCH.
- ori → alu_ctrl=001, ext_zero=1, alu_src_b=10 in EXI. slti → alu_ctrl=111. opcode 3F → illegal=1 for one cycle in DECODE, next state FETCH, no writes.
- Without MULTI_CTRL_WAIT_EN and mem_ready=0: sw completes in 4 cycles with states 0,1,2,5.
